// File: rtl/wreg_hazard_unit.sv
// Destination tracking through EX/MEM and MEM/WB, forwarding selects and load-use stall.
// Optional saturating stall counter on stall_count when HAZ_STALL_CNT_EN is defined.
module wreg_hazard_unit #(
    parameter bit FWD_WB_EN_DEFAULT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ex_wreg,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       stall,
    output logic [4:0] mem_wreg,
    output logic [4:0] wb_wreg,
    output logic       mem_regwrite,
    output logic       wb_regwrite
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    logic mem_eff;
    logic wb_eff;
    logic mem_a, mem_b;
    logic wb_a, wb_b;

    // The MEM-stage load flag is not kept: a load-use hazard is fully
    // resolved by the single ID/EX bubble, so nothing downstream reads it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wreg     <= 5'd0;
            mem_regwrite <= 1'b0;
            wb_wreg      <= 5'd0;
            wb_regwrite  <= 1'b0;
        end else begin
            if (flush) begin
                mem_wreg     <= 5'd0;
                mem_regwrite <= 1'b0;
            end else begin
                mem_wreg     <= ex_wreg;
                mem_regwrite <= ex_regwrite;
            end
            wb_wreg     <= mem_wreg;
            wb_regwrite <= mem_regwrite;
        end
    end

    assign mem_eff = mem_regwrite && (mem_wreg != 5'd0);
    assign wb_eff  = FWD_WB_EN_DEFAULT && wb_regwrite
                     && (wb_wreg != 5'd0);

    assign mem_a = mem_eff && (mem_wreg == ex_rs);
    assign mem_b = mem_eff && (mem_wreg == ex_rt);
    assign wb_a  = wb_eff && (wb_wreg == ex_rs);
    assign wb_b  = wb_eff && (wb_wreg == ex_rt);

    always_comb begin
        fwd_a = 2'b00;
        unique case (1'b1)
            mem_a:          fwd_a = 2'b10;
            wb_a && !mem_a: fwd_a = 2'b01;
            default:        fwd_a = 2'b00;
        endcase
    end

    always_comb begin
        fwd_b = 2'b00;
        unique case (1'b1)
            mem_b:          fwd_b = 2'b10;
            wb_b && !mem_b: fwd_b = 2'b01;
            default:        fwd_b = 2'b00;
        endcase
    end

    assign stall = ex_memread && ex_regwrite
                   && (ex_wreg != 5'd0)
                   && ((ex_wreg == id_rs) || (ex_wreg == id_rt))
                   && !flush;

`ifdef HAZ_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
